axis_ps_to_pl: RTL and testbench
================================

AXIS_PS_TO_PL -- requirements
Module: axis_ps_to_pl

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, input beat width; SHALL divide 256 evenly; RATIO = 256/DATA_WIDTH (8 at default).
REQ-002 Ports SHALL be, in order:
- pl_clk  input  1  sole clock; all logic on rising edge; one clock, no clock-domain crossing.
- rst  input  1  synchronous, active-high reset.
- s_axis_tdata  input  DATA_WIDTH  narrow input beat.
- s_axis_tvalid  input  1  input beat valid.
- s_axis_tready  output  1  block accepts input beat.
- m_axis_tdata  output  256  packed wide output word.
- m_axis_tvalid  output  1  output word valid.
- m_axis_tready  input  1  downstream accepts output word.
REQ-003 No tlast, tkeep or tuser; every group of RATIO accepted input beats forms exactly one output word.

Function
REQ-004 Input transfer SHALL occur on a rising edge with s_axis_tvalid=1 and s_axis_tready=1; output transfer SHALL occur with m_axis_tvalid=1 and m_axis_tready=1.
REQ-005 Packing is little-endian: the k-th accepted beat of a group (k=0..RATIO-1) SHALL occupy m_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH]; the first beat lands in bits [DATA_WIDTH-1:0].
REQ-006 Internal state: beat counter 0..RATIO-1, accumulator of (RATIO-1) beats, registered output word plus m_axis_tvalid flag.
REQ-007 Beats 0..RATIO-2 of a group SHALL be accepted into the accumulator whenever s_axis_tvalid=1, regardless of output-register state (s_axis_tready=1 while counter < RATIO-1).
REQ-008 The last beat (counter = RATIO-1) SHALL be accepted only when the output register is free or drained that cycle: s_axis_tready = !(counter==RATIO-1 && m_axis_tvalid && !m_axis_tready).
REQ-009 On accepting the last beat, the accumulator plus that beat SHALL load m_axis_tdata, m_axis_tvalid SHALL be 1 from the next cycle, and the counter SHALL wrap to 0; latency is 1 cycle from last-beat acceptance to valid output.
REQ-010 m_axis_tvalid SHALL clear after an output transfer unless a new word loads the same edge; simultaneous drain and load SHALL keep m_axis_tvalid=1 with the new data, with no bubble.
REQ-011 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tvalid SHALL hold stable.
REQ-012 Sustained throughput with m_axis_tready held 1: one input beat per cycle, one output word every RATIO cycles.
REQ-013 s_axis_tready SHALL be a combinational function of registered state and m_axis_tready only, never of s_axis_tvalid.
REQ-014 No data transformation is applied: payload bits pass unchanged, including all-ones and zero beats.

Reset
REQ-015 While rst=1 at a rising edge: counter=0, accumulator=0, m_axis_tdata=0, m_axis_tvalid=0; a partially collected group is discarded.
REQ-016 During reset s_axis_tready SHALL be driven 1 but no beat is captured; the first beat after rst deasserts SHALL be beat 0 of a new group.
REQ-017 Reset asserted mid-group or with a pending output word SHALL drop that data; no output word SHALL appear for it after reset.

Verification
REQ-018 Reset: rst=1 for 10 cycles with s_axis_tvalid=1 -> m_axis_tvalid=0, m_axis_tdata=0 throughout, and no output after release until 8 new beats arrive.
REQ-019 Ramp: m_axis_tready=1; stream 0x00000000, 0x11111111 ... 0xFFFFFFFF, wrapping to 0 -> words 256'h77777777_66666666_55555555_44444444_33333333_22222222_11111111_00000000, then 256'hFFFFFFFF_EEEEEEEE_..._88888888, repeating; m_axis_tvalid pulses 1 cycle every 8, 1 cycle after each 8th beat.
REQ-020 Backpressure: m_axis_tready=0 with continuous input -> 8 beats produce a held word, 7 more beats accepted, s_axis_tready=0 at the 16th beat; raising m_axis_tready drains and accepts it the same edge with no data loss.
REQ-021 Gappy input: s_axis_tvalid toggled randomly -> output words are identical to the gap-free case.
REQ-022 Mid-group reset: 3 beats accepted, rst pulsed for 1 cycle, then 8 beats A0..A7 -> single word {A7..A0}, none of the pre-reset beats present.

Source files
------------

// File: rtl/axis_ps_to_pl.sv
// Narrow-to-256-bit AXI-Stream packer: collects 256/DATA_WIDTH input beats
// little-endian into one registered output word on a single clock.
module axis_ps_to_pl #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  pl_clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [255:0]          m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready
);

   localparam int RATIO = 256 / DATA_WIDTH;
   localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

   if (256 % DATA_WIDTH != 0) begin : g_bad_width
      $error("axis_ps_to_pl: DATA_WIDTH must divide 256");
   end

   logic [CW-1:0] r_cnt;
   logic [255:0]  r_acc;
   logic [255:0]  r_data;
   logic          r_valid;

   logic          w_last;
   logic          w_accept;
   logic [255:0]  w_word;

   // Only the closing beat waits on the output register; earlier beats always
   // fit in the accumulator, so the source is never stalled mid-group.
   assign w_last        = (r_cnt == LAST);
   assign s_axis_tready = rst || !(w_last && r_valid && !m_axis_tready);
   assign w_accept      = s_axis_tvalid && s_axis_tready;

   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      w_word = r_acc;
      w_word[(RATIO-1)*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers
   // update together from pre-edge values.
   always_ff @(posedge pl_clk) begin
      if (rst) begin
         // NOTE: the accumulator is reset too, so a discarded partial group can
         // never leak stale beats into a later word.
         r_cnt   <= '0;
         r_acc   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         if (m_axis_tready) begin
            r_valid <= 1'b0;
         end
         if (w_accept) begin
            if (w_last) begin
               // A load on the same edge as a drain overrides the clear above.
               r_data  <= w_word;
               r_valid <= 1'b1;
               r_cnt   <= '0;
            end else begin
               for (int k = 0; k < RATIO - 1; k++) begin
                  if (r_cnt == CW'(k)) begin
                     r_acc[k*DATA_WIDTH +: DATA_WIDTH] <= s_axis_tdata;
                  end
               end
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign m_axis_tdata  = r_data;
   assign m_axis_tvalid = r_valid;

endmodule

// File: tb/tb_axis_ps_to_pl.sv
// Directed self-checking bench for axis_ps_to_pl at DATA_WIDTH=32 (8 beats per word).
module tb_axis_ps_to_pl;

   localparam logic [255:0] W_RAMP0 = 256'h77777777_66666666_55555555_44444444_33333333_22222222_11111111_00000000;
   localparam logic [255:0] W_RAMP1 = 256'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA_99999999_88888888;
   localparam logic [255:0] W_BP0   = 256'hB0000007_B0000006_B0000005_B0000004_B0000003_B0000002_B0000001_B0000000;
   localparam logic [255:0] W_BP1   = 256'hB000000F_B000000E_B000000D_B000000C_B000000B_B000000A_B0000009_B0000008;
   localparam logic [255:0] W_A     = 256'hA0000007_A0000006_A0000005_A0000004_A0000003_A0000002_A0000001_A0000000;

   logic         pl_clk = 1'b0;
   logic         rst;
   logic [31:0]  s_axis_tdata;
   logic         s_axis_tvalid;
   logic         s_axis_tready;
   logic [255:0] m_axis_tdata;
   logic         m_axis_tvalid;
   logic         m_axis_tready;

   int n_checks = 0;
   int n_fail   = 0;
   logic [255:0] q_out[$];

   always #5 pl_clk = ~pl_clk;

   axis_ps_to_pl #(.DATA_WIDTH(32)) dut (
      .pl_clk        (pl_clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready)
   );

   // Inputs only change 1 ns after a rising edge, so the falling edge sees the
   // exact handshake the next rising edge will act on.
   always @(negedge pl_clk) begin
      if (!rst && m_axis_tvalid && m_axis_tready) q_out.push_back(m_axis_tdata);
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge pl_clk);
      #1;
   endtask

   function automatic logic [31:0] ramp(input int i);
      logic [3:0] n;
      n = 4'(i % 16);
      return {8{n}};
   endfunction

   initial begin
      int  idx;
      logic took;
      logic [31:0] gap;

      // Reset held with valid input: nothing captured, outputs cleared.
      rst = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 32'h12345678; m_axis_tready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         s_axis_tdata = s_axis_tdata + 32'h01010101;
         check("rst_valid",  m_axis_tvalid, 1'b0);
         check("rst_data",   m_axis_tdata,  '0);
         check("rst_tready", s_axis_tready, 1'b1);
      end
      rst = 1'b0; s_axis_tvalid = 1'b0;
      repeat (4) tick();
      check("post_rst_quiet", q_out.size(), 0);

      // Ramp, four words back to back; valid pulses one cycle after every 8th beat.
      q_out.delete();
      for (int i = 0; i < 32; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = ramp(i);
         check("ramp_tready", s_axis_tready, 1'b1);
         tick();
         check("ramp_valid", m_axis_tvalid, (i % 8 == 7));
         if (i % 8 == 7) check("ramp_word", m_axis_tdata, (i % 16 == 7) ? W_RAMP0 : W_RAMP1);
      end
      s_axis_tvalid = 1'b0;
      tick();
      check("ramp_valid_end", m_axis_tvalid, 1'b0);
      check("ramp_count", q_out.size(), 4);
      if (q_out.size() == 4) begin
         check("ramp_q0", q_out[0], W_RAMP0);
         check("ramp_q1", q_out[1], W_RAMP1);
         check("ramp_q2", q_out[2], W_RAMP0);
         check("ramp_q3", q_out[3], W_RAMP1);
      end

      // Backpressure: 15 beats accepted, 16th stalls until the held word drains.
      q_out.delete();
      m_axis_tready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = 32'hB0000000 | 32'(i);
         check("bp_tready", s_axis_tready, (i != 15));
         if (i < 15) tick();
      end
      repeat (3) begin
         tick();
         check("bp_hold_valid",  m_axis_tvalid, 1'b1);
         check("bp_hold_data",   m_axis_tdata,  W_BP0);
         check("bp_hold_tready", s_axis_tready, 1'b0);
      end
      m_axis_tready = 1'b1;
      #1;
      check("bp_release_tready", s_axis_tready, 1'b1);
      tick();
      check("bp_reload_valid", m_axis_tvalid, 1'b1);
      check("bp_reload_data",  m_axis_tdata,  W_BP1);
      s_axis_tvalid = 1'b0;
      tick();
      check("bp_drained", m_axis_tvalid, 1'b0);
      check("bp_count", q_out.size(), 2);
      if (q_out.size() == 2) begin
         check("bp_q0", q_out[0], W_BP0);
         check("bp_q1", q_out[1], W_BP1);
      end

      // Gappy input: same ramp with a fixed on/off valid pattern.
      q_out.delete();
      gap = 32'b1011_0010_1110_0101_1001_1101_0100_0111;
      idx = 0;
      for (int cyc = 0; cyc < 200 && idx < 16; cyc++) begin
         s_axis_tvalid = gap[cyc % 32];
         s_axis_tdata  = ramp(idx);
         took = s_axis_tvalid && s_axis_tready;
         tick();
         if (took) idx++;
      end
      s_axis_tvalid = 1'b0;
      tick();
      check("gap_beats", idx, 16);
      check("gap_count", q_out.size(), 2);
      if (q_out.size() == 2) begin
         check("gap_q0", q_out[0], W_RAMP0);
         check("gap_q1", q_out[1], W_RAMP1);
      end

      // Mid-group reset: three stale beats must vanish.
      q_out.delete();
      for (int i = 0; i < 3; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = 32'hDEAD0000 | 32'(i);
         tick();
      end
      rst = 1'b1; s_axis_tdata = 32'hDEADBEEF;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         s_axis_tdata = 32'hA0000000 + 32'(i);
         tick();
      end
      check("mid_valid", m_axis_tvalid, 1'b1);
      check("mid_word",  m_axis_tdata,  W_A);
      s_axis_tvalid = 1'b0;
      tick();
      check("mid_count", q_out.size(), 1);
      if (q_out.size() == 1) check("mid_q0", q_out[0], W_A);

      // Reset with a pending output word: it must never be delivered.
      q_out.delete();
      m_axis_tready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = 32'hC0000000 + 32'(i);
         tick();
      end
      s_axis_tvalid = 1'b0;
      check("pend_valid", m_axis_tvalid, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("pend_rst_valid", m_axis_tvalid, 1'b0);
      check("pend_rst_data",  m_axis_tdata,  '0);
      m_axis_tready = 1'b1;
      repeat (3) tick();
      check("pend_dropped", q_out.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
